// File: rtl/optimsoc.sv
// Shared optimsoc types: one trace event layout for tiles, monitors and trace sinks.
package optimsoc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] r3;
  } trace_event_t;

  localparam int TRACE_EVENT_W = $bits(trace_event_t);

endpackage

// File: rtl/trace_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module trace_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_idx
);

  logic                found;
  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/trace_event_arbiter.sv
// Funnels per-core trace events through one-deep slots into a single registered valid/ready stream.
// Cores are never stalled: an event hitting a full slot that is not leaving this cycle is dropped and counted.
module trace_event_arbiter
  import optimsoc::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  in_valid,
  input  trace_event_t [NUM_REQ-1:0]          in_event,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ID_WIDTH-1:0]                 out_id,
  output trace_event_t                        out_event,
  output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   drop_cnt,
  output logic                                drop_any
);

  logic [NUM_REQ-1:0]                slot_full_q, slot_full_d;
  trace_event_t [NUM_REQ-1:0]        slot_evt_q, slot_evt_d;
  logic                              out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0]               out_id_q, out_id_d;
  trace_event_t                      out_event_q, out_event_d;
  logic [ID_WIDTH-1:0]               rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                              drop_any_q, drop_any_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                load;
  logic [NUM_REQ-1:0]  free;

  trace_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req     (slot_full_q),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign load = (!out_valid_q || out_ready) && (|slot_full_q);
  assign free = load ? gnt : '0;

  always_comb begin
    slot_full_d = slot_full_q;
    slot_evt_d  = slot_evt_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_event_d = out_event_q;
    rr_ptr_d    = rr_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    drop_any_d  = drop_any_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_id_d    = gnt_idx;
      out_event_d = slot_evt_q[gnt_idx];
      rr_ptr_d    = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A slot leaving this cycle can take a new event in the same edge, so a steady stream never bubbles.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (free[i]) slot_full_d[i] = 1'b0;
      if (in_valid[i]) begin
        if (!slot_full_q[i] || free[i]) begin
          slot_evt_d[i]  = in_event[i];
          slot_full_d[i] = 1'b1;
        end else begin
          if (drop_cnt_q[i] != '1) drop_cnt_d[i] = drop_cnt_q[i] + CNT_WIDTH'(1);
          drop_any_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full_q <= '0;
      slot_evt_q  <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_event_q <= '0;
      rr_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      drop_any_q  <= 1'b0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_evt_q  <= slot_evt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_event_q <= out_event_d;
      rr_ptr_q    <= rr_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_any_q  <= drop_any_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_event = out_event_q;
  assign drop_cnt  = drop_cnt_q;
  assign drop_any  = drop_any_q;

endmodule
